// File: rtl/eth_rx_framer_if.sv
// rtl/eth_rx_framer_if.sv - PHY-side byte stream in, framed byte stream and end-of-frame status out
interface eth_rx_framer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 11
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_dv;
  logic                  rx_er;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  frame_done;
  logic                  frame_good;
  logic                  err_crc;
  logic                  err_runt;
  logic                  err_giant;
  logic                  err_phy;
  logic [LEN_W-1:0]      frame_len;

  modport master (
    output rx_data, rx_valid, rx_dv, rx_er,
    input  out_data, out_valid, frame_done, frame_good,
    input  err_crc, err_runt, err_giant, err_phy, frame_len
  );

  modport slave (
    input  rx_data, rx_valid, rx_dv, rx_er,
    output out_data, out_valid, frame_done, frame_good,
    output err_crc, err_runt, err_giant, err_phy, frame_len
  );
endinterface

// File: rtl/eth_rx_framer.sv
// rtl/eth_rx_framer.sv - receive framer: strips preamble/SFD and FCS, checks CRC-32 and frame length
module eth_crc32_byte (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
    end
  end
endmodule

module eth_rx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_W      = 11
) (
  input logic            clk,
  input logic            rst,
  eth_rx_framer_if.slave bus
);
  localparam logic [7:0]       PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]       SFD_BYTE      = 8'hD5;
  localparam logic [LEN_W-1:0] MIN_L         = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L         = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FWD_LIMIT     = LEN_W'(MAX_LEN + 4);
  localparam logic [LEN_W-1:0] LEN_SAT       = '1;
  localparam logic [LEN_W-1:0] FCS_LEN       = LEN_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  state_t                          state, state_next;
  logic [2:0]                      pre_cnt;
  logic [3:0][DATA_WIDTH-1:0]      dl;
  logic [2:0]                      dl_cnt;
  logic [31:0]                     crc_reg, crc_next;
  logic [LEN_W-1:0]                len_cnt, len_inc;
  logic                            phy_flag;

  logic [DATA_WIDTH-1:0]           out_data_q;
  logic                            out_valid_q, frame_done_q, good_q;
  logic                            crc_q, runt_q, giant_q, phy_q;
  logic [LEN_W-1:0]                len_q;

  logic byte_ev, is_pre, is_sfd;
  logic pre_start, pre_more, sfd_hit, data_ev, eof;
  logic [31:0] fcs_rx;
  logic crc_bad, runt, giant;

  assign byte_ev = bus.rx_valid && bus.rx_dv;
  assign is_pre  = (bus.rx_data == PREAMBLE_BYTE);
  assign is_sfd  = (bus.rx_data == SFD_BYTE);

  // The CRC only ever sees bytes leaving the delay line, so it excludes the FCS.
  eth_crc32_byte u_crc (
    .crc_in  (crc_reg),
    .data    (dl[3]),
    .crc_out (crc_next)
  );

  // The FCS arrives least-significant byte first, so the oldest entry is byte 0.
  assign fcs_rx  = {dl[0], dl[1], dl[2], dl[3]};
  assign crc_bad = (~crc_reg != fcs_rx) || (len_cnt < FCS_LEN);
  assign runt    = (len_cnt < MIN_L);
  assign giant   = (len_cnt > MAX_L);
  assign len_inc = (len_cnt == LEN_SAT) ? len_cnt : len_cnt + LEN_W'(1);

  // Reset lands in DROP so a frame still in flight is ignored until carrier drops.
  always_ff @(posedge clk) begin
    if (rst) state <= S_DROP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pre_start  = 1'b0;
    pre_more   = 1'b0;
    sfd_hit    = 1'b0;
    data_ev    = 1'b0;
    eof        = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_ev) begin
          if (is_pre) begin
            state_next = S_PREAMBLE;
            pre_start  = 1'b1;
          end else begin
            state_next = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_next = S_IDLE;
        end else if (bus.rx_valid) begin
          if (is_pre && pre_cnt != 3'd7) begin
            pre_more = 1'b1;
          end else if (is_sfd) begin
            state_next = S_DATA;
            sfd_hit    = 1'b1;
          end else begin
            state_next = S_DROP;
          end
        end
      end
      S_DATA: begin
        if (!bus.rx_dv) begin
          state_next = S_IDLE;
          eof        = 1'b1;
        end else begin
          data_ev = bus.rx_valid;
        end
      end
      S_DROP: begin
        if (!bus.rx_dv) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt      <= '0;
      dl           <= '0;
      dl_cnt       <= '0;
      crc_reg      <= 32'hFFFFFFFF;
      len_cnt      <= '0;
      phy_flag     <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      good_q       <= 1'b0;
      crc_q        <= 1'b0;
      runt_q       <= 1'b0;
      giant_q      <= 1'b0;
      phy_q        <= 1'b0;
      len_q        <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (pre_start) begin
        pre_cnt  <= 3'd1;
        phy_flag <= bus.rx_er;
      end
      if (pre_more) begin
        pre_cnt  <= pre_cnt + 3'd1;
        phy_flag <= phy_flag | bus.rx_er;
      end
      if (sfd_hit) begin
        crc_reg  <= 32'hFFFFFFFF;
        len_cnt  <= '0;
        dl       <= '0;
        dl_cnt   <= '0;
        phy_flag <= phy_flag | bus.rx_er;
      end
      if (data_ev) begin
        len_cnt  <= len_inc;
        phy_flag <= phy_flag | bus.rx_er;
        dl       <= {dl[2:0], bus.rx_data};
        if (dl_cnt == 3'd4) begin
          crc_reg <= crc_next;
          // The emitted byte is four behind the one arriving; stop once it passes MAX_LEN.
          if (len_cnt < FWD_LIMIT) begin
            out_valid_q <= 1'b1;
            out_data_q  <= dl[3];
          end
        end else begin
          dl_cnt <= dl_cnt + 3'd1;
        end
      end
      if (eof) begin
        frame_done_q <= 1'b1;
        crc_q        <= crc_bad;
        runt_q       <= runt;
        giant_q      <= giant;
        phy_q        <= phy_flag;
        good_q       <= !(crc_bad || runt || giant || phy_flag);
        len_q        <= len_cnt;
        dl           <= '0;
        dl_cnt       <= '0;
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_good = good_q;
  assign bus.err_crc    = crc_q;
  assign bus.err_runt   = runt_q;
  assign bus.err_giant  = giant_q;
  assign bus.err_phy    = phy_q;
  assign bus.frame_len  = len_q;
endmodule

// File: tb/tb_eth_rx_framer.sv
// tb/tb_eth_rx_framer.sv - self-checking bench for eth_rx_framer
module tb_eth_rx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_rx_framer_if bus ();
  eth_rx_framer dut (.clk(clk), .rst(rst), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          done_cnt = 0;
  logic [4:0]  st_flags = '0;  // {good, crc, runt, giant, phy}
  logic [10:0] st_len = '0;
  logic [7:0]  std_pre[$];

  always @(negedge clk) begin
    if (bus.out_valid) got_q.push_back(bus.out_data);
    if (bus.frame_done) begin
      done_cnt <= done_cnt + 1;
      st_flags <= {bus.frame_good, bus.err_crc, bus.err_runt, bus.err_giant, bus.err_phy};
      st_len   <= bus.frame_len;
    end
  end

  // Normal-order shift-left CRC-32; the reflected FCS is its bit-reverse, inverted.
  function automatic logic [31:0] fcs_ref(input logic [7:0] q[$]);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ q[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return ~r;
  endfunction

  task automatic build_frame(input int n_data, output logic [7:0] f[$]);
    logic [31:0] fcs;
    f = {};
    for (int i = 0; i < n_data; i++) f.push_back(8'(i));
    fcs = fcs_ref(f);
    for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
  endtask

  task automatic push_exp(input logic [7:0] f[$], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
  endtask

  function automatic int drain_mismatches();
    int n = 0;
    while (exp_q.size() > 0 && got_q.size() > 0)
      if (exp_q.pop_front() !== got_q.pop_front()) n++;
    n += exp_q.size() + got_q.size();
    exp_q.delete();
    got_q.delete();
    return n;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic er);
    @(negedge clk);
    bus.rx_dv    = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rx_er    = er;
  endtask

  task automatic end_frame(input int idle);
    @(negedge clk);
    bus.rx_dv    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_er    = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] pre[$], input logic [7:0] f[$], input int gap_max,
                      input int er_idx, input int idle);
    foreach (pre[i]) drive_byte(pre[i], 1'b0);
    foreach (f[i]) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          @(negedge clk);
          bus.rx_valid = 1'b0;
          bus.rx_er    = 1'b0;
        end
      end
      drive_byte(f[i], i == er_idx);
    end
    end_frame(idle);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_dv = 1'b0; bus.rx_valid = 1'b0; bus.rx_er = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.frame_done, bus.frame_good, bus.err_crc, bus.err_runt, bus.err_giant, bus.err_phy} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0", {bus.out_valid, bus.frame_done, bus.frame_good});
    end
    checks++;
    if (bus.frame_len !== 11'd0 || bus.out_data !== 8'd0) begin
      errors++; $display("FAIL reset_len_data: got len %0d data %h expected 0", bus.frame_len, bus.out_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_min(input string name, input int gap_max, input int er_idx, input logic [4:0] exp_flags);
    logic [7:0] f[$];
    int d0, n;
    build_frame(60, f);
    push_exp(f, 60);
    d0 = done_cnt;
    send(std_pre, f, gap_max, er_idx, 3);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL %s_done: got %0d expected 1", name, done_cnt - d0); end
    checks++;
    if (st_flags !== exp_flags) begin errors++; $display("FAIL %s_flags: got %b expected %b", name, st_flags, exp_flags); end
    checks++;
    if (st_len !== 11'd64) begin errors++; $display("FAIL %s_len: got %0d expected 64", name, st_len); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, got_q.size(), exp_q.size()); end
    n = drain_mismatches();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL %s_bytes: got %0d mismatches expected 0", name, n); end
  endtask

  task automatic test_bad_fcs();
    logic [7:0] f[$];
    int d0, n;
    build_frame(60, f);
    f[60] = f[60] ^ 8'h01;
    push_exp(f, 60);
    d0 = done_cnt;
    send(std_pre, f, 0, -1, 3);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL bad_fcs_done: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (st_flags !== 5'b01000) begin errors++; $display("FAIL bad_fcs_flags: got %b expected 01000", st_flags); end
    checks++;
    if (st_len !== 11'd64) begin errors++; $display("FAIL bad_fcs_len: got %0d expected 64", st_len); end
    n = drain_mismatches();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL bad_fcs_bytes: got %0d mismatches expected 0", n); end
  endtask

  task automatic test_length(input string name, input int n_data, input int n_fwd, input logic [4:0] exp_flags);
    logic [7:0] f[$];
    int d0, n;
    build_frame(n_data, f);
    push_exp(f, n_fwd);
    d0 = done_cnt;
    send(std_pre, f, 0, -1, 3);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL %s_done: got %0d expected 1", name, done_cnt - d0); end
    checks++;
    if (st_flags !== exp_flags) begin errors++; $display("FAIL %s_flags: got %b expected %b", name, st_flags, exp_flags); end
    checks++;
    if (st_len !== 11'(n_data + 4)) begin errors++; $display("FAIL %s_len: got %0d expected %0d", name, st_len, n_data + 4); end
    checks++;
    if (got_q.size() !== n_fwd) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, got_q.size(), n_fwd); end
    n = drain_mismatches();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL %s_bytes: got %0d mismatches expected 0", name, n); end
  endtask

  task automatic test_preamble_faults();
    logic [7:0] f[$];
    logic [7:0] pre_bad[$];
    logic [7:0] pre_long[$];
    int d0;
    build_frame(60, f);
    pre_bad = '{8'h55, 8'h55, 8'h54};
    for (int i = 0; i < 8; i++) pre_long.push_back(8'h55);
    pre_long.push_back(8'hD5);
    d0 = done_cnt;
    send(pre_bad, f, 0, -1, 3);
    checks++;
    if (done_cnt !== d0 || got_q.size() !== 0) begin
      errors++; $display("FAIL pre_bad: got done %0d bytes %0d expected 0 0", done_cnt - d0, got_q.size());
    end
    send(pre_long, f, 0, -1, 3);
    checks++;
    if (done_cnt !== d0 || got_q.size() !== 0) begin
      errors++; $display("FAIL pre_long: got done %0d bytes %0d expected 0 0", done_cnt - d0, got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[$];
    int d0, n;
    build_frame(60, f);
    push_exp(f, 26);
    d0 = done_cnt;
    foreach (std_pre[i]) drive_byte(std_pre[i], 1'b0);
    for (int i = 0; i < 30; i++) drive_byte(f[i], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_data = f[30];
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.frame_done, bus.frame_good, bus.err_crc, bus.err_runt, bus.err_giant, bus.err_phy} !== 7'b0) begin
      errors++; $display("FAIL midrst_flags: got %b expected 0", {bus.out_valid, bus.frame_done, bus.frame_good});
    end
    checks++;
    if (bus.frame_len !== 11'd0 || bus.out_data !== 8'd0) begin
      errors++; $display("FAIL midrst_len_data: got len %0d data %h expected 0", bus.frame_len, bus.out_data);
    end
    rst = 1'b0;
    for (int i = 31; i < 64; i++) drive_byte(f[i], 1'b0);
    end_frame(3);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL midrst_done: got %0d expected 0", done_cnt - d0); end
    checks++;
    if (got_q.size() !== 26) begin errors++; $display("FAIL midrst_count: got %0d expected 26", got_q.size()); end
    n = drain_mismatches();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL midrst_bytes: got %0d mismatches expected 0", n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[$];
    int d0, n;
    build_frame(60, f);
    push_exp(f, 60);
    push_exp(f, 60);
    d0 = done_cnt;
    send(std_pre, f, 0, -1, 0);
    send(std_pre, f, 0, -1, 3);
    checks++;
    if (done_cnt !== d0 + 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
    checks++;
    if (st_flags !== 5'b10000 || st_len !== 11'd64) begin
      errors++; $display("FAIL b2b_status: got %b len %0d expected 10000 len 64", st_flags, st_len);
    end
    checks++;
    if (got_q.size() !== 120) begin errors++; $display("FAIL b2b_count: got %0d expected 120", got_q.size()); end
    n = drain_mismatches();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL b2b_bytes: got %0d mismatches expected 0", n); end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) std_pre.push_back(8'h55);
    std_pre.push_back(8'hD5);
    test_reset();
    test_good_min("good_min", 0, -1, 5'b10000);
    test_bad_fcs();
    test_length("runt", 36, 36, 5'b00100);
    test_length("giant", 1596, 1518, 5'b00010);
    test_preamble_faults();
    test_good_min("after_pre", 0, -1, 5'b10000);
    test_good_min("gaps", 3, -1, 5'b10000);
    test_good_min("gaps_er", 3, 20, 5'b00001);
    test_reset_mid();
    test_good_min("after_rst", 0, -1, 5'b10000);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
